// File: rtl/multicycle_adder_de2.sv
// Multi-cycle ripple adder: WIDTH-bit operands summed CHUNK bits per clock, LSB chunk first.
// Define MULTICYCLE_ADDER_SUB_EN to add a SUB input that turns the operation into A - B.
`timescale 1ns/1ps

module multicycle_adder_de2 #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef MULTICYCLE_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BEATS = WIDTH / CHUNK;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [BW-1:0]    beat;
    logic             last_beat;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is folded into the capture path: A + ~B + 1, so the datapath stays add-only.
`ifdef MULTICYCLE_ADDER_SUB_EN
    assign b_eff   = SUB ? ~B : B;
    assign cin_eff = SUB ? 1'b1 : CIN;
`else
    assign b_eff   = B;
    assign cin_eff = CIN;
`endif

    always_comb begin
        {chunk_cout, chunk_sum} = {1'b0, a_sh[CHUNK-1:0]}
                                + {1'b0, b_sh[CHUNK-1:0]}
                                + (CHUNK+1)'(carry);
    end

    // Each new chunk enters at the MSB end, so after BEATS shifts the LSB chunk sits at bit 0.
    generate
        if (BEATS == 1) begin : g_single
            assign res_next = chunk_sum;
        end else begin : g_multi
            assign res_next = {chunk_sum, res_sh[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign last_beat = (beat == BW'(BEATS - 1));

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_RUN;
            S_RUN:   if (last_beat) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign BUSY = (state != S_IDLE);
    assign DONE = (state == S_DONE);

    // SUM/COUT/OVF live apart from the shift register so partial sums are never visible.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            beat   <= '0;
            SUM    <= '0;
            COUT   <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            if (state == S_IDLE && START) begin
                a_sh  <= A;
                b_sh  <= b_eff;
                carry <= cin_eff;
                a_msb <= A[WIDTH-1];
                b_msb <= b_eff[WIDTH-1];
                beat  <= '0;
            end else if (state == S_RUN) begin
                a_sh   <= a_sh >> CHUNK;
                b_sh   <= b_sh >> CHUNK;
                carry  <= chunk_cout;
                res_sh <= res_next;
                beat   <= beat + BW'(1);
                if (last_beat) begin
                    SUM  <= res_next;
                    COUT <= chunk_cout;
                    OVF  <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                end
            end
        end
    end

endmodule
